uart_rx: RTL and testbench

//   Asynchronous serial receiver, 8N1 (8E1/8O1 with parity option). Peer of uart_tx: it consumes the

---
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver with 2-FF line synchroniser and mid-bit sampling.
// Define UART_RX_PARITY_EN for a parity bit after D7 (PARITY_ODD picks the sense).
module uart_rx #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_busy
);

    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] LAST    = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } state_t;
`endif

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;
    logic          rx_meta_q;
    logic          rx_s_q;
`ifdef UART_RX_PARITY_EN
    logic          par_q;
    logic          perr_q;
    logic          par_bad;

    assign par_bad = (^shift_q ^ par_q) != PARITY_ODD;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
            // Saturating baud counter; every sample point reloads it.
            if (cnt_q != LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        state_q <= rx_s_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        par_q   <= rx_s_q;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                perr_q <= 1'b1;
                            end else begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
`else
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`endif
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 12 clocks per bit.
// Parity checks are built only with UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int CPB = 12;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       perr;
    logic       par_flip = 1'b0;
    int         perr_cnt = 0;
`endif

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         last_valid_cyc = 0;
    logic [7:0] rxq[$];

    uart_rx #(
        .CLK_HZ(12000000),
        .BAUD  (1000000)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .o_frame_err (ferr),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(perr),
`endif
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            rxq.push_back(data);
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        if (ferr) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
        if (perr) perr_cnt++;
`endif
        if (valid || ferr) check("excl", {31'b0, valid & ferr}, 32'd0);
    end

    task automatic bit_time(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(^d ^ par_flip);
`endif
        bit_time(stop);
        rx = 1'b1;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [31:0] got;
        got = 32'hDEAD;
        if (rxq.size() > 0) got = {24'b0, rxq.pop_front()};
        check(tag, got, {24'b0, exp});
    endtask

    initial begin
        int v0;
        int f0;
        int t0;
        logic [7:0] hello[5];
        hello[0] = 8'h48;
        hello[1] = 8'h65;
        hello[2] = 8'h6C;
        hello[3] = 8'h6C;
        hello[4] = 8'h6F;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'b0, data}, 32'h0);
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_ferr", {31'b0, ferr}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Single good frame, latency and idle afterwards
        rxq.delete();
        v0 = valid_cnt;
        t0 = cyc;
        send_frame(8'h48, 1'b1);
        check("t1_count", valid_cnt - v0, 32'd1);
        expect_byte("t1_data", 8'h48);
        check("t1_lat", {31'b0, (last_valid_cyc - t0 >= LAT - 1) &&
                                (last_valid_cyc - t0 <= LAT + 1)}, 32'd1);
        check("t1_busy", {31'b0, busy}, 32'h0);
        repeat (2 * CPB) @(negedge clk);

        // Short glitch is rejected
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("t2_busy", {31'b0, busy}, 32'h0);
        check("t2_valid", valid_cnt - v0, 32'd0);
        check("t2_ferr", ferr_cnt - f0, 32'd0);
        repeat (2 * CPB) @(negedge clk);

        // Framing error followed by long break, then recovery
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0);
        rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("t3_ferr", ferr_cnt - f0, 32'd1);
        check("t3_valid", valid_cnt - v0, 32'd0);
        check("t3_hold", {24'b0, data}, 32'h48);
        rxq.delete();
        send_frame(8'h3C, 1'b1);
        repeat (CPB) @(negedge clk);
        check("t3_count", valid_cnt - v0, 32'd1);
        expect_byte("t3_data", 8'h3C);

        // Back-to-back frames
        rxq.delete();
        v0 = valid_cnt;
        for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("t4_count", valid_cnt - v0, 32'd5);
        for (int i = 0; i < 5; i++) expect_byte($sformatf("t4_b%0d", i), hello[i]);

        // Reset during data bit 4; upper bits of 0xF0 keep the line high
        rxq.delete();
        v0 = valid_cnt;
        f0 = ferr_cnt;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (62) @(negedge clk);
                check("t5_busy_pre", {31'b0, busy}, 32'h1);
                rst = 1'b1;
                @(negedge clk);
                check("t5_data", {24'b0, data}, 32'h0);
                check("t5_valid", {31'b0, valid}, 32'h0);
                check("t5_busy", {31'b0, busy}, 32'h0);
                rst = 1'b0;
            end
        join
        repeat (2 * CPB) @(negedge clk);
        check("t5_nostrobe", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);
        send_frame(8'h81, 1'b1);
        repeat (CPB) @(negedge clk);
        check("t5_count", valid_cnt - v0, 32'd1);
        expect_byte("t5_after", 8'h81);

`ifdef UART_RX_PARITY_EN
        // Even parity: good then flipped parity bit
        rxq.delete();
        v0 = valid_cnt;
        f0 = perr_cnt;
        send_frame(8'h07, 1'b1);
        repeat (CPB) @(negedge clk);
        check("t6_good", valid_cnt - v0, 32'd1);
        expect_byte("t6_data", 8'h07);
        check("t6_noperr", perr_cnt - f0, 32'd0);
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        repeat (CPB) @(negedge clk);
        check("t6_perr", perr_cnt - f0, 32'd1);
        check("t6_novalid", valid_cnt - v0, 32'd1);
        check("t6_hold", {24'b0, data}, 32'h07);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
